row_cache: RTL and testbench

- Fully-associative row cache for the DDR emulation path.
- Maps a DRAM row address (RowId) onto one of 2**CHWIDTH local cache-row slots and reports the slot on cRowId.
- On a miss, it stalls the requester via hold while the emulated writeback/fill latency elapses.
- sync flushes all dirty lines back to backing memory.

---
 rtl/row_cache_pkg.sv | 24 ++
 rtl/row_cache_lookup.sv | 50 +++++
 rtl/row_cache.sv | 186 ++++++++++++++++++
 tb/tb_row_cache.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/row_cache_pkg.sv
// Shared types and default latencies for the fully-associative DRAM row cache.
package row_cache_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FILL      = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  localparam int DEF_CHWIDTH     = 5;
  localparam int DEF_ADDRWIDTH   = 17;
  localparam int DEF_WB_CYCLES   = 2;
  localparam int DEF_FILL_CYCLES = 2;

  // Shared down-counter / flush-scan counter width.
  localparam int CNTW = 16;

  // Terminal count for an operation lasting n cycles (counter runs n-1 .. 0).
  function automatic logic [CNTW-1:0] last_cnt(input int n);
    return (n > 1) ? CNTW'(n - 1) : '0;
  endfunction

endpackage

// File: rtl/row_cache_lookup.sv
// Combinational tag CAM for the row cache: hit detection plus victim choice
// (lowest-index invalid slot, else the round-robin replacement pointer).
module row_cache_lookup
  import row_cache_pkg::*;
#(
  parameter int CHWIDTH   = DEF_CHWIDTH,
  parameter int ADDRWIDTH = DEF_ADDRWIDTH
) (
  input  logic [(1<<CHWIDTH)-1:0][ADDRWIDTH+1:0] ents,
  input  logic [ADDRWIDTH-1:0]                   RowId,
  input  logic [CHWIDTH-1:0]                     ptr,
  output logic                                   hit,
  output logic [CHWIDTH-1:0]                     hit_slot,
  output logic                                   free_found,
  output logic [CHWIDTH-1:0]                     victim
);
  localparam int CHROWS = 1 << CHWIDTH;

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [ADDRWIDTH-1:0] tag;
  } entry_t;

  logic [CHWIDTH-1:0] free_slot;

  // Scan downward so the lowest matching / free index wins.
  always_comb begin
    entry_t e;
    e          = '0;
    hit        = 1'b0;
    hit_slot   = '0;
    free_found = 1'b0;
    free_slot  = '0;
    for (int i = CHROWS - 1; i >= 0; i--) begin
      e = ents[i];
      if (e.valid && (e.tag == RowId)) begin
        hit      = 1'b1;
        hit_slot = CHWIDTH'(i);
      end
      if (!e.valid) begin
        free_found = 1'b1;
        free_slot  = CHWIDTH'(i);
      end
    end
  end

  assign victim = free_found ? free_slot : ptr;

endmodule

// File: rtl/row_cache.sv
// Fully-associative DRAM row cache with emulated writeback/fill stalls and a
// dirty-line flush. Defining ROW_CACHE_STATS_EN adds hit/miss/writeback counters.
module row_cache
  import row_cache_pkg::*;
#(
  parameter int CHWIDTH     = DEF_CHWIDTH,
  parameter int ADDRWIDTH   = DEF_ADDRWIDTH,
  parameter int WB_CYCLES   = DEF_WB_CYCLES,
  parameter int FILL_CYCLES = DEF_FILL_CYCLES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RD,
  input  logic                 WR,
  input  logic [ADDRWIDTH-1:0] RowId,
  input  logic                 sync,
  output logic [CHWIDTH-1:0]   cRowId,
  output logic                 hold
`ifdef ROW_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_cnt,
  output logic [31:0]          miss_cnt,
  output logic [31:0]          wb_cnt
`endif
);
  localparam int              CHROWS     = 1 << CHWIDTH;
  localparam logic [CNTW-1:0] WB_LAST    = last_cnt(WB_CYCLES);
  localparam logic [CNTW-1:0] FILL_LAST  = last_cnt(FILL_CYCLES);
  localparam logic [CNTW-1:0] FLUSH_LAST = CNTW'(CHROWS - 1);

  typedef struct packed {
    logic                 valid;
    logic                 dirty;
    logic [ADDRWIDTH-1:0] tag;
  } entry_t;

  state_t               st, st_nxt;
  logic [CNTW-1:0]      cnt, cnt_nxt;
  logic [CHWIDTH-1:0]   ptr;
  logic [CHWIDTH-1:0]   lat_slot;
  logic                 lat_wr;
  logic [ADDRWIDTH-1:0] lat_tag;
  logic                 sync_pend;
  logic [CHROWS-1:0]    valid;
  logic [CHROWS-1:0]    dirty;
  logic [ADDRWIDTH-1:0] tags [CHROWS];
  entry_t [CHROWS-1:0]  ents;

  logic                 hit, free_found;
  logic [CHWIDTH-1:0]   hit_slot, victim;
  logic                 idle, req, flush_go, acc_hit, acc_miss;
  logic                 victim_dirty, fill_done;

  always_comb begin
    for (int i = 0; i < CHROWS; i++) begin
      ents[i] = '{valid: valid[i], dirty: dirty[i], tag: tags[i]};
    end
  end

  row_cache_lookup #(
    .CHWIDTH   (CHWIDTH),
    .ADDRWIDTH (ADDRWIDTH)
  ) u_lookup (
    .ents       (ents),
    .RowId      (RowId),
    .ptr        (ptr),
    .hit        (hit),
    .hit_slot   (hit_slot),
    .free_found (free_found),
    .victim     (victim)
  );

  // A flush request outranks any request presented in the same IDLE cycle.
  assign idle         = (st == IDLE);
  assign req          = RD | WR;
  assign flush_go     = idle && (sync || sync_pend);
  assign acc_hit      = idle && !flush_go && req && hit;
  assign acc_miss     = idle && !flush_go && req && !hit;
  assign victim_dirty = valid[victim] && dirty[victim];
  assign fill_done    = (st == FILL) && (cnt == '0);

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    unique case (st)
      IDLE: begin
        if (flush_go) begin
          st_nxt  = FLUSH;
          cnt_nxt = '0;
        end else if (acc_miss) begin
          if (victim_dirty && (WB_CYCLES > 0)) begin
            st_nxt  = WRITEBACK;
            cnt_nxt = WB_LAST;
          end else begin
            st_nxt  = FILL;
            cnt_nxt = FILL_LAST;
          end
        end
      end
      WRITEBACK: begin
        if (cnt == '0) begin
          st_nxt  = FILL;
          cnt_nxt = FILL_LAST;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      FILL: begin
        if (cnt == '0) st_nxt = IDLE;
        else           cnt_nxt = cnt - 1'b1;
      end
      FLUSH: begin
        if (cnt == FLUSH_LAST) st_nxt = IDLE;
        else                   cnt_nxt = cnt + 1'b1;
      end
      default: st_nxt = IDLE;
    endcase
  end

  // Control and cache metadata state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st        <= IDLE;
      cnt       <= '0;
      ptr       <= '0;
      sync_pend <= 1'b0;
      valid     <= '0;
      dirty     <= '0;
      lat_slot  <= '0;
      lat_wr    <= 1'b0;
      cRowId    <= '0;
      hold      <= 1'b0;
    end else begin
      st   <= st_nxt;
      cnt  <= cnt_nxt;
      hold <= (st_nxt != IDLE);

      if (flush_go)              sync_pend <= 1'b0;
      else if (sync && !idle)    sync_pend <= 1'b1;

      if (acc_hit) begin
        cRowId <= hit_slot;
        if (WR) dirty[hit_slot] <= 1'b1;
      end

      if (acc_miss) begin
        lat_slot <= victim;
        lat_wr   <= WR;
        if (!free_found) ptr <= ptr + 1'b1;
      end

      if (fill_done) begin
        valid[lat_slot] <= 1'b1;
        dirty[lat_slot] <= lat_wr;
        cRowId          <= lat_slot;
      end

      if (st == FLUSH) dirty[cnt[CHWIDTH-1:0]] <= 1'b0;
    end
  end

  // Tag storage carries no reset; valid bits qualify it.
  always_ff @(posedge clk) begin
    if (acc_miss)  lat_tag        <= RowId;
    if (fill_done) tags[lat_slot] <= lat_tag;
  end

`ifdef ROW_CACHE_STATS_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else begin
      if (acc_hit)                  hit_cnt  <= sat_inc(hit_cnt);
      if (acc_miss)                 miss_cnt <= sat_inc(miss_cnt);
      if (acc_miss && victim_dirty) wb_cnt   <= sat_inc(wb_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_row_cache.sv
// Self-checking bench for row_cache: directed scenarios plus randomized traffic
// against a stall-budget reference model of the cache.
module tb_row_cache;
  localparam int CH   = 32;
  localparam int WB   = 2;
  localparam int FILL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        RD = 1'b0, WR = 1'b0, sync = 1'b0;
  logic [16:0] RowId = '0;
  logic [4:0]  cRowId;
  logic        hold;
`ifdef ROW_CACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt, wb_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  row_cache dut (
    .clk    (clk),
    .rst    (rst),
    .RD     (RD),
    .WR     (WR),
    .RowId  (RowId),
    .sync   (sync),
    .cRowId (cRowId),
    .hold   (hold)
`ifdef ROW_CACHE_STATS_EN
    ,
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .wb_cnt   (wb_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a cache line table plus a remaining-stall budget.
  bit   mvalid [CH];
  bit   mdirty [CH];
  int   mtag   [CH];
  int   mptr, m_busy, m_crow, m_slot, m_row, hs, fs;
  bit   m_spend, m_fill, m_wr;
  int   m_hit, m_miss, m_wb;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) begin mvalid[i] = 0; mdirty[i] = 0; mtag[i] = 0; end
      mptr = 0; m_busy = 0; m_crow = 0; m_spend = 0; m_fill = 0;
      m_hit = 0; m_miss = 0; m_wb = 0;
    end else if (m_busy > 0) begin
      if (sync) m_spend = 1;
      m_busy--;
      if (m_busy == 0 && m_fill) begin
        mvalid[m_slot] = 1; mdirty[m_slot] = m_wr; mtag[m_slot] = m_row;
        m_crow = m_slot; m_fill = 0;
      end
    end else if (sync || m_spend) begin
      m_spend = 0;
      m_busy  = CH;
      for (int i = 0; i < CH; i++) mdirty[i] = 0;
    end else if (RD || WR) begin
      hs = -1; fs = -1;
      for (int i = 0; i < CH; i++) begin
        if (mvalid[i] && mtag[i] == int'(RowId)) hs = i;
        if (!mvalid[i] && fs < 0) fs = i;
      end
      if (hs >= 0) begin
        m_crow = hs;
        if (WR) mdirty[hs] = 1;
        m_hit++;
      end else begin
        if (fs >= 0) m_slot = fs;
        else begin m_slot = mptr; mptr = (mptr + 1) % CH; end
        m_busy = FILL + ((mvalid[m_slot] && mdirty[m_slot]) ? WB : 0);
        if (mvalid[m_slot] && mdirty[m_slot]) m_wb++;
        m_row = int'(RowId); m_wr = WR; m_fill = 1;
        m_miss++;
      end
    end
  end

  // Every-cycle comparison on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      chk("hold", int'(hold), (m_busy != 0) ? 1 : 0);
      chk("cRowId", int'(cRowId), m_crow);
`ifdef ROW_CACHE_STATS_EN
      chk("hit_cnt", int'(hit_cnt), m_hit);
      chk("miss_cnt", int'(miss_cnt), m_miss);
      chk("wb_cnt", int'(wb_cnt), m_wb);
`endif
    end
  end

  task automatic wait_low(output int n);
    n = 0;
    while (hold && n < 300) begin
      n++;
      @(posedge clk); #1;
    end
    if (n >= 300) begin
      n_assert++; n_fail++;
      $display("FAIL hold_timeout: hold still high after %0d cycles", n);
    end
  endtask

  // Present a request and keep it stable until hold is low; returns stall cycles.
  task automatic do_req(input logic rd, input logic wr, input int row,
                        input int sync_at, output int stall);
    RD = rd; WR = wr; RowId = 17'(row); stall = 0;
    @(posedge clk); #1;
    while (hold && stall < 300) begin
      if (stall == sync_at) sync = 1'b1;
      stall++;
      @(posedge clk); #1;
      sync = 1'b0;
    end
    if (stall >= 300) begin
      n_assert++; n_fail++;
      $display("FAIL req_timeout: hold still high after %0d cycles", stall);
    end
    RD = 1'b0; WR = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("reset_hold", int'(hold), 0);
    chk("reset_crow", int'(cRowId), 0);
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic pulse_sync();
    sync = 1'b1;
    @(posedge clk); #1;
    sync = 1'b0;
  endtask

  int s, n;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("init_hold", int'(hold), 0);
    chk("init_crow", int'(cRowId), 0);

    // First miss, hit, second miss, read hit.
    do_req(0, 1, 150, -1, s); chk("wr150_stall", s, 2); chk("wr150_slot", int'(cRowId), 0);
    do_req(0, 1, 150, -1, s); chk("wr150_hit_stall", s, 0); chk("wr150_hit_slot", int'(cRowId), 0);
    do_req(0, 1, 590, -1, s); chk("wr590_stall", s, 2); chk("wr590_slot", int'(cRowId), 1);
    do_req(1, 0, 150, -1, s); chk("rd150_stall", s, 0); chk("rd150_slot", int'(cRowId), 0);

    // Fill every slot dirty, then evict with writeback; pointer advances.
    do_reset();
    for (int i = 0; i < CH; i++) begin
      do_req(0, 1, i, -1, s);
      chk("fill_stall", s, 2); chk("fill_slot", int'(cRowId), i);
    end
    do_req(0, 1, 1000, -1, s); chk("evict0_stall", s, 4); chk("evict0_slot", int'(cRowId), 0);
    do_req(0, 1, 1001, -1, s); chk("evict1_stall", s, 4); chk("evict1_slot", int'(cRowId), 1);

    // Flush with two dirty lines, then a clean eviction of a former dirty slot.
    do_reset();
    do_req(0, 1, 0, -1, s);
    do_req(0, 1, 1, -1, s);
    for (int i = 2; i < CH; i++) do_req(1, 0, i, -1, s);
    pulse_sync(); wait_low(n); chk("flush_len", n, 32);
    do_req(1, 0, 2000, -1, s); chk("post_flush_stall", s, 2); chk("post_flush_slot", int'(cRowId), 0);

    // sync during FILL: fill completes, one idle cycle, then a full flush.
    do_req(1, 0, 3000, 0, s); chk("fill_sync_stall", s, 2); chk("fill_sync_slot", int'(cRowId), 1);
    @(posedge clk); #1;
    chk("pending_flush_hold", int'(hold), 1);
    wait_low(n); chk("pending_flush_len", n, 32);

    // RD and WR together install a dirty line.
    do_reset();
    do_req(1, 1, 7, -1, s); chk("rdwr_stall", s, 2); chk("rdwr_slot", int'(cRowId), 0);
    for (int i = 1; i < CH; i++) do_req(1, 0, 99 + i, -1, s);
    do_req(1, 0, 5000, -1, s); chk("rdwr_dirty_evict", s, 4); chk("rdwr_evict_slot", int'(cRowId), 0);
    do_req(0, 1, 100, -1, s); chk("wr100_hit", s, 0); chk("wr100_slot", int'(cRowId), 1);

    // Reset asserted in the middle of a writeback.
    RD = 1'b1; RowId = 17'd6000;
    @(posedge clk); #1;
    chk("wb_started", int'(hold), 1);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_hold", int'(hold), 0);
    chk("async_rst_crow", int'(cRowId), 0);
    RD = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    do_req(1, 0, 100, -1, s); chk("after_rst_miss", s, 2); chk("after_rst_slot", int'(cRowId), 0);

    // Randomized traffic over a row pool larger than the cache.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      int op, row, sa;
      op  = $urandom_range(0, 15);
      row = $urandom_range(0, 47);
      sa  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : -1;
      if (op == 0) pulse_sync();
      else if (op == 1) repeat ($urandom_range(1, 3)) @(posedge clk);
      else if (op < 6) do_req(0, 1, row, sa, s);
      else if (op == 6) do_req(1, 1, row, sa, s);
      else do_req(1, 0, row, sa, s);
      #0;
    end
    wait_low(n);
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
